// File: rtl/serial_compare.sv
// rtl/serial_compare.sv - nibble-serial magnitude comparator with 74HC85-style cascade inputs
// One 4-bit slice is compared per clock, most significant slice first.
module serial_compare #(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             igt,
  input  logic             ilt,
  input  logic             ieq,
  output logic             busy,
  output logic             done,
  output logic             fgt,
  output logic             flt,
  output logic             feq
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cgt;
  logic             clt;
  logic             ceq;
  logic             found;
  logic             hit_gt;

  logic [WIDTH-1:0] msb_mask;
  logic [3:0]       sa;
  logic [3:0]       sb;
  logic             diff;
  logic             last;
  logic             finish;
  logic             res_gt;
  logic             res_lt;
  logic             res_eq;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_mask = {signed_mode, {(WIDTH-1){1'b0}}};

  assign sa     = a_r[{idx, 2'b00} +: 4];
  assign sb     = b_r[{idx, 2'b00} +: 4];
  assign diff   = (sa != sb);
  assign last   = (idx == '0);
  assign finish = (state == S_RUN) && (last || ((EARLY_EXIT != 0) && diff));

  // Result presented on the edge that enters DONE: a mismatch seen this cycle,
  // else the first mismatch remembered earlier, else the cascade inputs.
  always_comb begin
    res_gt = 1'b0;
    res_lt = 1'b0;
    res_eq = 1'b0;
    if (diff && !found) begin
      res_gt = (sa > sb);
      res_lt = (sa < sb);
    end else if (found) begin
      res_gt = hit_gt;
      res_lt = !hit_gt;
    end else begin
      res_gt = !ceq && !clt;
      res_lt = !ceq && !cgt;
      res_eq = ceq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      cgt    <= 1'b0;
      clt    <= 1'b0;
      ceq    <= 1'b0;
      found  <= 1'b0;
      hit_gt <= 1'b0;
      fgt    <= 1'b0;
      flt    <= 1'b0;
      feq    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r    <= a ^ msb_mask;
            b_r    <= b ^ msb_mask;
            cgt    <= igt;
            clt    <= ilt;
            ceq    <= ieq;
            idx    <= IW'(N - 1);
            found  <= 1'b0;
            hit_gt <= 1'b0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (diff && !found) begin
            found  <= 1'b1;
            hit_gt <= (sa > sb);
          end
          if (finish) begin
            fgt   <= res_gt;
            flt   <= res_lt;
            feq   <= res_eq;
            state <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_compare.sv
// tb/tb_serial_compare.sv - directed and back-to-back checks of serial_compare
// Instance e0 uses EARLY_EXIT=1, instance e1 uses EARLY_EXIT=0.
module tb_serial_compare;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        igt;
  logic        ilt;
  logic        ieq;
  logic        busy0, done0, fgt0, flt0, feq0;
  logic        busy1, done1, fgt1, flt1, feq1;

  int total;
  int bad;

  serial_compare #(.WIDTH(16), .EARLY_EXIT(1)) e0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .igt(igt), .ilt(ilt), .ieq(ieq),
    .busy(busy0), .done(done0), .fgt(fgt0), .flt(flt0), .feq(feq0)
  );

  serial_compare #(.WIDTH(16), .EARLY_EXIT(0)) e1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .igt(igt), .ilt(ilt), .ieq(ieq),
    .busy(busy1), .done(done1), .fgt(fgt1), .flt(flt1), .feq(feq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic        ig;
    logic        il;
    logic        ie;
    logic [2:0]  res;   // {fgt, flt, feq}
    int          lat;   // EARLY_EXIT=1 latency
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: first differing nibble from the top decides, else cascade inputs.
  function automatic void model(input logic [15:0] va, vb, input logic vsm, vig, vil, vie,
                                output logic [2:0] r, output int lat);
    logic [15:0] ua, ub;
    logic [3:0]  na, nb;
    ua  = va ^ {vsm, 15'b0};
    ub  = vb ^ {vsm, 15'b0};
    lat = -1;
    r   = 3'b000;
    for (int j = 3; j >= 0; j--) begin
      na = ua[j*4 +: 4];
      nb = ub[j*4 +: 4];
      if (lat < 0 && na != nb) begin
        r   = {na > nb, na < nb, 1'b0};
        lat = 4 - j;
      end
    end
    if (lat < 0) begin
      r   = {!vie && !vil, !vie && !vig, vie};
      lat = 4;
    end
  endfunction

  // One idle cycle, one start sample, then corrupt inputs and wait for both dones.
  task automatic run_one(input logic [15:0] va, vb, input logic vsm, vig, vil, vie,
                         output logic [2:0] r0, r1, output int l0, l1);
    @(posedge clk); #1;
    a = va; b = vb; signed_mode = vsm; igt = vig; ilt = vil; ieq = vie;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~va; b = ~vb; signed_mode = ~vsm; igt = ~vig; ilt = ~vil; ieq = ~vie;
    l0 = -1; l1 = -1; r0 = 3'b000; r1 = 3'b000;
    for (int k = 1; k <= 20 && (l0 < 0 || l1 < 0); k++) begin
      @(posedge clk); #1;
      if (done0 && l0 < 0) begin l0 = k; r0 = {fgt0, flt0, feq0}; end
      if (done1 && l1 < 0) begin l1 = k; r1 = {fgt1, flt1, feq1}; end
    end
  endtask

  initial begin
    logic [2:0]  r0, r1, er;
    logic [15:0] na, nb, ca, cb;
    logic        nsm, nig, nil, nie, csm, cig, cil, cie;
    int          l0, l1, el, cnt0, cnt1, lat;
    logic        seen_eq;

    total = 0; bad = 0;
    start = 1'b0; a = '0; b = '0; signed_mode = 1'b0; igt = 1'b0; ilt = 1'b0; ieq = 1'b0;

    tv[0]  = '{16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 4};
    tv[1]  = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1};
    tv[2]  = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1};
    tv[3]  = '{16'h00F1, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 4};
    tv[4]  = '{16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1};
    tv[5]  = '{16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 4};
    tv[6]  = '{16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 4};
    tv[7]  = '{16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 4};
    tv[8]  = '{16'h5A5A, 16'h5A5A, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 4};
    tv[9]  = '{16'h0120, 16'h0130, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3};
    tv[10] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1};
    tv[11] = '{16'hFFFE, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 4};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_e0", {busy0, done0, fgt0, flt0, feq0}, 5'b0);
    chk("reset_e1", {busy1, done1, fgt1, flt1, feq1}, 5'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_one(tv[i].a, tv[i].b, tv[i].sm, tv[i].ig, tv[i].il, tv[i].ie, r0, r1, l0, l1);
      chk($sformatf("vec%0d_res_e0", i), r0, tv[i].res);
      chk($sformatf("vec%0d_lat_e0", i), l0, tv[i].lat);
      chk($sformatf("vec%0d_res_e1", i), r1, tv[i].res);
      chk($sformatf("vec%0d_lat_e1", i), l1, 4);
    end

    // start kept high through every RUN cycle must not queue a second operation
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; igt = 1'b0; ilt = 1'b0; ieq = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    a = 16'hFFFF; ieq = 1'b0;
    cnt0 = 0; cnt1 = 0; seen_eq = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 4) start = 1'b0;
      if (done0) begin cnt0++; seen_eq = feq0; end
      if (done1) cnt1++;
    end
    chk("ignore_start_e0_dones", cnt0, 1);
    chk("ignore_start_e1_dones", cnt1, 1);
    chk("ignore_start_e0_feq", seen_eq, 1'b1);

    // reset in the middle of RUN aborts without a done pulse
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h1234; ieq = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_e0", {busy0, done0, fgt0, flt0, feq0}, 5'b0);
    chk("abort_e1", {busy1, done1, fgt1, flt1, feq1}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done0 || done1) cnt0++;
    end
    chk("abort_no_done", cnt0, 0);
    run_one(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, r0, r1, l0, l1);
    chk("post_reset_res_e0", r0, 3'b010);
    chk("post_reset_lat_e0", l0, 1);
    chk("post_reset_res_e1", r1, 3'b010);
    chk("post_reset_lat_e1", l1, 4);

    // back-to-back with start held high on the early-exit instance
    @(posedge clk); #1;
    na = 16'($urandom); nb = na; nsm = 1'b0; nig = 1'b0; nil = 1'b0; nie = 1'b1;
    a = na; b = nb; signed_mode = nsm; igt = nig; ilt = nil; ieq = nie;
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      ca = na; cb = nb; csm = nsm; cig = nig; cil = nil; cie = nie;
      a = 16'($urandom); b = 16'($urandom);
      {signed_mode, igt, ilt, ieq} = 4'($urandom);
      model(ca, cb, csm, cig, cil, cie, er, el);
      lat = -1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
        @(posedge clk); #1;
        if (done0) lat = k;
      end
      if (lat < 0) begin
        chk($sformatf("b2b%0d_timeout", i), 32'd0, 32'd1);
        break;
      end
      chk($sformatf("b2b%0d a=%h b=%h sm=%0d c=%0d%0d%0d", i, ca, cb, csm, cig, cil, cie),
          {lat[7:0], 5'b0, fgt0, flt0, feq0}, {el[7:0], 5'b0, er});
      na = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       nb = na;
        1:       nb = na ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
        default: nb = 16'($urandom);
      endcase
      {nsm, nig, nil, nie} = 4'($urandom);
      a = na; b = nb; signed_mode = nsm; igt = nig; ilt = nil; ieq = nie;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
